// File: rtl/grant_service_queue_if.sv
// rtl/grant_service_queue_if.sv - grant inputs and service/status outputs of grant_service_queue
interface grant_service_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            a1;
  logic            a2;
  logic            a3;
  logic            s1;
  logic            s2;
  logic            s3;
  logic            busy;
  logic            done;
  logic            full;
  logic            drop;
  logic            mhot;
  logic [CNTW-1:0] count;

  modport master (
    output a1, a2, a3,
    input  s1, s2, s3, busy, done, full, drop, mhot, count
  );

  modport slave (
    input  a1, a2, a3,
    output s1, s2, s3, busy, done, full, drop, mhot, count
  );
endinterface

// File: rtl/grant_service_queue.sv
// rtl/grant_service_queue.sv - queues arbiter grant IDs and serves them in fixed-length windows
// A FIFO of requester IDs feeds a two-state server that drives a one-hot select per window.
module grant_service_queue #(
  parameter int DEPTH      = 4,
  parameter int SVC_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  grant_service_queue_if.slave   gif
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (SVC_CYCLES > 1) ? $clog2(SVC_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [CW-1:0]   SVC_LOAD = CW'(SVC_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   svc_q, svc_d;
  logic [2:0]      sel_q, sel_d;
  logic            done_q, done_d;
  logic            full_q, full_d;
  logic            drop_q, drop_d;
  logic            mhot_q, mhot_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];

  logic       any_grant;
  logic       multi_grant;
  logic [1:0] push_id;
  logic [1:0] pop_id;
  logic       push;
  logic       pop;
  logic       svc_end;

  always_comb begin
    any_grant   = gif.a1 | gif.a2 | gif.a3;
    multi_grant = (gif.a1 & gif.a2) | (gif.a1 & gif.a3) | (gif.a2 & gif.a3);
    if (gif.a1)      push_id = 2'd1;
    else if (gif.a2) push_id = 2'd2;
    else             push_id = 2'd3;

    // full is the pre-edge value, so a grant racing a pop from a full queue is lost
    push    = any_grant & ~full_q;
    drop_d  = any_grant & full_q;
    mhot_d  = multi_grant;

    svc_end = (state_q == ST_SERVE) && (svc_q == '0);
    pop     = (count_q != '0) && ((state_q == ST_IDLE) || svc_end);
    pop_id  = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    full_d  = (count_d == CNT_FULL);
  end

  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    sel_d   = sel_q;
    if (pop) begin
      // back-to-back windows: reload straight from the last cycle of the previous one
      state_d = ST_SERVE;
      svc_d   = SVC_LOAD;
      case (pop_id)
        2'd1:    sel_d = 3'b001;
        2'd2:    sel_d = 3'b010;
        default: sel_d = 3'b100;
      endcase
    end else if (svc_end) begin
      state_d = ST_IDLE;
      sel_d   = 3'b000;
    end else if (state_q == ST_SERVE) begin
      svc_d = svc_q - CW'(1);
    end
    done_d = (state_d == ST_SERVE) && (svc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      svc_q    <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
      mhot_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      svc_q    <= svc_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
      mhot_q   <= mhot_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign gif.s1    = sel_q[0];
  assign gif.s2    = sel_q[1];
  assign gif.s3    = sel_q[2];
  assign gif.busy  = (state_q == ST_SERVE);
  assign gif.done  = done_q;
  assign gif.full  = full_q;
  assign gif.drop  = drop_q;
  assign gif.mhot  = mhot_q;
  assign gif.count = count_q;
endmodule

// File: tb/tb_grant_service_queue.sv
// tb/tb_grant_service_queue.sv - directed vector bench for grant_service_queue
module tb_grant_service_queue;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  grant_service_queue_if #(.DEPTH(4)) gif ();

  grant_service_queue #(.DEPTH(4), .SVC_CYCLES(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .gif  (gif)
  );

  typedef struct {
    string      nm;
    logic       r;
    logic [2:0] a;
    logic [2:0] s;
    logic       bz;
    logic       dn;
    logic       fl;
    logic       dr;
    logic       mh;
    logic [2:0] c;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(string nm, logic r, logic [2:0] a, logic [2:0] s, logic bz,
                             logic dn, logic fl, logic dr, logic mh, logic [2:0] c);
    vec_t x;
    x.nm = nm; x.r = r; x.a = a; x.s = s; x.bz = bz;
    x.dn = dn; x.fl = fl; x.dr = dr; x.mh = mh; x.c = c;
    return x;
  endfunction

  function automatic logic [10:0] obs();
    return {gif.s3, gif.s2, gif.s1, gif.busy, gif.done, gif.full, gif.drop, gif.mhot, gif.count};
  endfunction

  initial begin
    // single grant a2
    vecs.push_back(v("single_t0",  1, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("single_t1",  1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v("single_t2",  1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("single_t3",  1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("single_t4",  1, 3'b000, 3'b010, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v("single_t5",  1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
    // a3, a1, a2 back to back
    vecs.push_back(v("order_t0",   1, 3'b100, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("order_t1",   1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v("order_t2",   1, 3'b010, 3'b100, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("order_t3",   1, 3'b000, 3'b100, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v("order_t4",   1, 3'b000, 3'b100, 1, 1, 0, 0, 0, 2));
    vecs.push_back(v("order_t5",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("order_t6",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("order_t7",   1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 1));
    vecs.push_back(v("order_t8",   1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("order_t9",   1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("order_t10",  1, 3'b000, 3'b010, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v("order_t11",  1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
    // a1 held 8 cycles: fill, drop, drop with coincident pop, then drain
    vecs.push_back(v("hold_t0",    1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("hold_t1",    1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v("hold_t2",    1, 3'b001, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("hold_t3",    1, 3'b001, 3'b001, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v("hold_t4",    1, 3'b001, 3'b001, 1, 1, 0, 0, 0, 3));
    vecs.push_back(v("hold_t5",    1, 3'b001, 3'b001, 1, 0, 0, 0, 0, 3));
    vecs.push_back(v("hold_t6",    1, 3'b001, 3'b001, 1, 0, 1, 0, 0, 4));
    vecs.push_back(v("hold_t7",    1, 3'b001, 3'b001, 1, 1, 1, 1, 0, 4));
    vecs.push_back(v("hold_t8",    1, 3'b000, 3'b001, 1, 0, 0, 1, 0, 3));
    vecs.push_back(v("hold_t9",    1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 3));
    vecs.push_back(v("hold_t10",   1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 3));
    vecs.push_back(v("hold_t11",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v("hold_t12",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v("hold_t13",   1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 2));
    vecs.push_back(v("hold_t14",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("hold_t15",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("hold_t16",   1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 1));
    vecs.push_back(v("hold_t17",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("hold_t18",   1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("hold_t19",   1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v("hold_t20",   1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
    // a1+a2 together
    vecs.push_back(v("mhot_t0",    1, 3'b011, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("mhot_t1",    1, 3'b000, 3'b000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v("mhot_t2",    1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("mhot_t3",    1, 3'b000, 3'b001, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("mhot_t4",    1, 3'b000, 3'b001, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v("mhot_t5",    1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
    // reset in the second service cycle with two entries queued
    vecs.push_back(v("rst_t0",     1, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("rst_t1",     1, 3'b010, 3'b000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v("rst_t2",     1, 3'b100, 3'b001, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v("rst_t3",     0, 3'b000, 3'b001, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v("rst_t4",     1, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v("rst_t5",     1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v("rst_t6",     1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("rst_t7",     1, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v("rst_t8",     1, 3'b000, 3'b010, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v("rst_t9",     1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));

    rstn   = 1'b0;
    gif.a1 = 1'b0;
    gif.a2 = 1'b0;
    gif.a3 = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      logic [10:0] exp_v;
      logic [10:0] act_v;
      @(posedge clk);
      #1;
      rstn   = vecs[i].r;
      gif.a1 = vecs[i].a[0];
      gif.a2 = vecs[i].a[1];
      gif.a3 = vecs[i].a[2];
      @(negedge clk);
      exp_v = {vecs[i].s, vecs[i].bz, vecs[i].dn, vecs[i].fl, vecs[i].dr, vecs[i].mh, vecs[i].c};
      act_v = obs();
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got s/busy/done/full/drop/mhot/count=%b want %b", vecs[i].nm, act_v, exp_v);
      end
    end

    // grant a3 from idle: done must land exactly four cycles after the grant cycle
    begin
      int n;
      @(posedge clk);
      #1;
      gif.a3 = 1'b1;
      @(posedge clk);
      #1;
      gif.a3 = 1'b0;
      n = 1;
      while (gif.done !== 1'b1 && n < 12) begin
        @(posedge clk);
        #1;
        n++;
      end
      total++;
      if (n != 4) begin
        bad++;
        $display("FAIL done_latency: got cycle %0d want 4", n);
      end
      total++;
      if ({gif.s3, gif.s2, gif.s1} !== 3'b100) begin
        bad++;
        $display("FAIL done_select: got %b want 100", {gif.s3, gif.s2, gif.s1});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
